// File: rtl/handwrite_canvas_pkg.sv
// Shared constants, state encoding and helpers for the handwriting canvas.
package handwrite_pkg;

  localparam int GRID      = 30;
  localparam int FRAC      = 3;
  localparam int NCELL     = GRID * GRID;
  localparam int POS_MAX   = GRID * (1 << FRAC) - 1;
  localparam int HOME_CELL = 15;
  localparam logic [7:0] POS_HOME = 8'(HOME_CELL << FRAC);

  typedef enum logic {IDLE, WALK} state_t;

  // Bit position of a cell inside the flattened bitmap.
  function automatic logic [9:0] cell_index(input logic [4:0] row, input logic [4:0] col);
    return 10'(int'(row) * GRID + int'(col));
  endfunction

  // Saturate a signed intermediate position onto the canvas range.
  function automatic logic [7:0] clamp_pos(input logic signed [9:0] v);
    if (int'(v) < 0)
      return 8'd0;
    else if (int'(v) > POS_MAX)
      return 8'(POS_MAX);
    else
      return v[7:0];
  endfunction

endpackage

// File: rtl/handwrite_canvas_if.sv
// Mouse-packet inputs and canvas/cursor outputs of the handwriting canvas.
interface handwrite_canvas_if;
  import handwrite_pkg::*;

  logic             i_valid;
  logic [8:0]       i_dx;
  logic [8:0]       i_dy;
  logic             i_lmb;
  logic             i_rmb;
  logic             i_clear;
  logic [NCELL-1:0] o_canvas;
  logic [4:0]       o_cur_col;
  logic [4:0]       o_cur_row;
  logic             o_busy;
  logic             o_overrun;

  // Packet source side (mouse decoder / bench).
  modport master (
    output i_valid, i_dx, i_dy, i_lmb, i_rmb, i_clear,
    input  o_canvas, o_cur_col, o_cur_row, o_busy, o_overrun
  );

  // Canvas side.
  modport slave (
    input  i_valid, i_dx, i_dy, i_lmb, i_rmb, i_clear,
    output o_canvas, o_cur_col, o_cur_row, o_busy, o_overrun
  );

endinterface

// File: rtl/handwrite_canvas.sv
// Integrates mouse deltas into a clamped cursor and draws pen strokes into a
// 30x30 bitmap, one cell per cycle, with a one-deep packet buffer.
//
// state | meaning
// IDLE  | waiting for a packet; a buffered packet wins over a new one
// WALK  | stepping cur toward tgt, setting one bitmap cell per cycle
module handwrite_canvas
  import handwrite_pkg::*;
(
  input logic               i_clk,
  input logic               i_rst,
  handwrite_canvas_if.slave bus
);

  state_t           state;
  logic [7:0]       pos_x, pos_y;
  logic [4:0]       cur_col, cur_row, tgt_col, tgt_row;
  logic [NCELL-1:0] canvas;
  logic             pend_valid, pend_lmb;
  logic [8:0]       pend_dx, pend_dy;
  logic             prev_pen;
  logic             overrun;

  logic               clr, acc, src_lmb;
  logic [8:0]         src_dx, src_dy;
  logic signed [9:0]  sum_x, sum_y;
  logic [7:0]         new_x, new_y;
  logic [4:0]         new_col, new_row, old_col, old_row;

  // Pick the packet to accept and compute its clamped destination.
  always_comb begin
    clr     = bus.i_clear | (bus.i_valid & bus.i_rmb);
    acc     = (state == IDLE) && (pend_valid || bus.i_valid) && !clr;
    src_dx  = pend_valid ? pend_dx  : bus.i_dx;
    src_dy  = pend_valid ? pend_dy  : bus.i_dy;
    src_lmb = pend_valid ? pend_lmb : bus.i_lmb;
    // Y delta is positive-up while rows grow downward, hence the subtraction.
    sum_x   = $signed({2'b00, pos_x}) + $signed({src_dx[8], src_dx});
    sum_y   = $signed({2'b00, pos_y}) - $signed({src_dy[8], src_dy});
    new_x   = clamp_pos(sum_x);
    new_y   = clamp_pos(sum_y);
    new_col = 5'(new_x >> FRAC);
    new_row = 5'(new_y >> FRAC);
    old_col = 5'(pos_x >> FRAC);
    old_row = 5'(pos_y >> FRAC);
  end

  // Cursor, packet buffer, stroke walker and bitmap; clear overrides everything.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      pos_x      <= POS_HOME;
      pos_y      <= POS_HOME;
      cur_col    <= '0;
      cur_row    <= '0;
      tgt_col    <= '0;
      tgt_row    <= '0;
      canvas     <= '0;
      pend_valid <= 1'b0;
      pend_lmb   <= 1'b0;
      pend_dx    <= '0;
      pend_dy    <= '0;
      prev_pen   <= 1'b0;
      overrun    <= 1'b0;
    end else if (clr) begin
      state      <= IDLE;
      pos_x      <= POS_HOME;
      pos_y      <= POS_HOME;
      canvas     <= '0;
      pend_valid <= 1'b0;
      prev_pen   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc) begin
            pos_x <= new_x;
            pos_y <= new_y;
            if (src_lmb) begin
              tgt_col  <= new_col;
              tgt_row  <= new_row;
              // Pen just went down: draw a dot instead of joining to the old spot.
              cur_col  <= prev_pen ? old_col : new_col;
              cur_row  <= prev_pen ? old_row : new_row;
              prev_pen <= 1'b1;
              state    <= WALK;
            end else begin
              prev_pen <= 1'b0;
            end
          end
          // Buffered packet is consumed now, so a coincident one takes its slot.
          if (pend_valid) begin
            pend_valid <= bus.i_valid;
            if (bus.i_valid) begin
              pend_dx  <= bus.i_dx;
              pend_dy  <= bus.i_dy;
              pend_lmb <= bus.i_lmb;
            end
          end
        end
        WALK: begin
          canvas[cell_index(cur_row, cur_col)] <= 1'b1;
          if (cur_col == tgt_col && cur_row == tgt_row) begin
            state <= IDLE;
          end else begin
            cur_col <= (tgt_col > cur_col) ? cur_col + 5'd1 :
                       (tgt_col < cur_col) ? cur_col - 5'd1 : cur_col;
            cur_row <= (tgt_row > cur_row) ? cur_row + 5'd1 :
                       (tgt_row < cur_row) ? cur_row - 5'd1 : cur_row;
          end
          if (bus.i_valid) begin
            if (pend_valid) begin
              overrun <= 1'b1;
            end else begin
              pend_valid <= 1'b1;
              pend_dx    <= bus.i_dx;
              pend_dy    <= bus.i_dy;
              pend_lmb   <= bus.i_lmb;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_canvas  = canvas;
  assign bus.o_cur_col = 5'(pos_x >> FRAC);
  assign bus.o_cur_row = 5'(pos_y >> FRAC);
  assign bus.o_busy    = (state == WALK);
  assign bus.o_overrun = overrun;

endmodule
